ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
Registered control sequencer for the simple CPU. It is the parametrised successor of the combinational next-state logic.
- Holds its own state register.
- Generates datapath strobes.
- Waits on a memory-ready handshake.
- Supports multi-cycle ALU latency.
- Adds HALT and illegal-opcode TRAP states.
Sits between the instruction register, register file, ALU and memory interface.

Parameters:
OPC_W, 4, opcode width (min 3); only codes 0-7 are legal, all higher codes trap.
ALU_LAT, 1, ALU execute cycles, legal range 1..16.
CNT_W, $clog2(ALU_LAT+1), localparam, latency counter width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  leaves IDLE; also resumes from HALT.
opcode  in  OPC_W  opcode from the IR, sampled in DECODE.
mem_ready  in  1  memory acknowledge for the current read.
cond  in  1  branch condition, sampled in BRANCH.
state  out  4  current state encoding, for debug.
mem_rd  out  1  memory read request.
ir_load  out  1  latch instruction register.
pc_inc  out  1  increment PC.
pc_load  out  1  load PC with branch target.
rf_we  out  1  register-file write enable.
acc_ld  out  1  latch ALU operand A.
alu_go  out  1  ALU execute strobe.
busy  out  1  high in every state except IDLE, HALT and TRAP.
halted  out  1  high in HALT.
trap  out  1  high in TRAP.

Behaviour:
- Reset: clk and rst are as already decided — one clock; reset is synchronous and active-high. On the rst edge, state becomes IDLE and the latency counter becomes 0. While rst is high, all strobe and status outputs are forced to 0 combinationally. Reset mid-instruction abandons the instruction; no write-back strobe is produced.
- Outputs are decoded from the state. FETCH and LOAD are additionally gated by mem_ready (Mealy) as noted below.
- IDLE: start=1 moves to FETCH; otherwise stay.
- FETCH: mem_rd=1. Stay while mem_ready=0. When mem_ready=1: ir_load=1 and pc_inc=1 in that cycle, then go to DECODE.
- DECODE: one cycle; no strobes. Next state by opcode:
  - 0 (load) -> LOAD
  - 1 (mov) -> MOV
  - 2, 3, 4, 5 (add/xor/or/and) -> ALU_A
  - 6 (branch) -> BRANCH
  - 7 (halt) -> HALT
  - any other code -> TRAP
- LOAD: mem_rd=1. Wait for mem_ready. When mem_ready=1: rf_we=1 that cycle, then go to FETCH.
- MOV: rf_we=1 for one cycle, then go to FETCH.
- ALU_A: acc_ld=1 for one cycle; counter loaded with ALU_LAT-1; go to ALU_EXEC.
- ALU_EXEC: alu_go=1. The counter decrements each cycle; at counter 0, go to ALU_WB. alu_go is therefore high for exactly ALU_LAT cycles.
- ALU_WB: rf_we=1 for one cycle, then go to FETCH.
- BRANCH: pc_load=cond for one cycle, then go to FETCH.
- HALT: halted=1. start=1 moves to FETCH; otherwise stay.
- TRAP: trap=1. Sticky; only rst exits.
- start is ignored in every state except IDLE and HALT.
- mem_ready is ignored outside FETCH and LOAD.
- An unused state encoding returns to IDLE on the next edge.
- Instruction length with mem_ready=1 (cycles from FETCH entry back to FETCH):
  - mov: 3
  - load: 3
  - ALU op: 4+ALU_LAT
  - branch: 3

Optional Feature:
CTRL_SINGLE_STEP_EN.
- Defined: adds input port `step` (1 bit) and state STEP_WAIT. Every transition into FETCH from MOV, LOAD, ALU_WB, BRANCH or HALT goes instead to STEP_WAIT. STEP_WAIT has busy=1 and no strobes; step=1 moves to FETCH. IDLE->FETCH is not gated.
- Undefined: the `step` port and STEP_WAIT do not exist; transitions go directly to FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum, 4-bit: IDLE, FETCH, DECODE, LOAD, MOV, ALU_A, ALU_EXEC, ALU_WB, BRANCH, HALT, TRAP, STEP_WAIT.
  - Opcode localparams OP_LOAD..OP_HALT.
- Natural sub-module: ctrl_lat_cnt, a loadable down-counter with zero flag, parametrised by CNT_W.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with mem_ready=1 -> all outputs 0 during reset; state FETCH one cycle after start; ir_load=pc_inc=1 in that FETCH cycle.
2. ALU_LAT=3, opcode=2, mem_ready=1 -> acc_ld pulses once, alu_go high exactly 3 cycles, rf_we one pulse; FETCH re-entered 7 cycles after the previous FETCH.
3. Opcode=0 with mem_ready held low 4 cycles in LOAD -> mem_rd high all 5 LOAD cycles; rf_we only in the cycle mem_ready=1.
4. Opcode=6 with cond=1, then cond=0 -> pc_load one-cycle pulse, then no pulse; FETCH follows both.
5. Opcode=7 -> halted=1 and busy=0; start=1 returns to FETCH. Opcode=9 -> trap=1, start ignored, rst clears to IDLE.
6. rst asserted mid-ALU_EXEC -> no rf_we pulse; state IDLE next cycle. With CTRL_SINGLE_STEP_EN: mov stalls in STEP_WAIT until step=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared state encoding and opcode constants for the control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        LOAD      = 4'd3,
        MOV       = 4'd4,
        ALU_A     = 4'd5,
        ALU_EXEC  = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        HALT      = 4'd9,
        TRAP      = 4'd10,
        STEP_WAIT = 4'd11
    } state_t;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_MOV    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_XOR    = 3'd3;
    localparam logic [2:0] OP_OR     = 3'd4;
    localparam logic [2:0] OP_AND    = 3'd5;
    localparam logic [2:0] OP_BRANCH = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    localparam int unsigned OP_LEGAL_MAX = 7;

endpackage

`default_nettype wire

// File: rtl/ctrl_lat_cnt.sv
// ============================================================================
// Module   : ctrl_lat_cnt
// Purpose  : Loadable down-counter with zero flag, times the ALU execute phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_lat_cnt #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Saturates at zero so a stray decrement can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ctrl_seq.sv
// ============================================================================
// Module   : ctrl_seq
// Purpose  : Registered control sequencer: fetch/decode/execute strobes, memory
//            handshake, multi-cycle ALU, HALT and illegal-opcode TRAP.
//            Optional build macro CTRL_SINGLE_STEP_EN adds a step port and STEP_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             cond,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [3:0]       state,
    output logic             mem_rd,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             rf_we,
    output logic             acc_ld,
    output logic             alu_go,
    output logic             busy,
    output logic             halted,
    output logic             trap
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] C_LAT_INIT = CNT_W'(ALU_LAT - 1);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t C_RET = STEP_WAIT;
`else
    localparam state_t C_RET = FETCH;
`endif

    state_t r_state;
    state_t w_next;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_zero;
    logic   w_opc_illegal;

    assign w_opc_illegal = (32'(opcode) > OP_LEGAL_MAX);
    assign state         = r_state;

    ctrl_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (C_LAT_INIT),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        mem_rd     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        rf_we      = 1'b0;
        acc_ld     = 1'b0;
        alu_go     = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) w_next = FETCH;
            end
            FETCH: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (w_opc_illegal) begin
                    w_next = TRAP;
                end else begin
                    case (opcode[2:0])
                        OP_LOAD:                        w_next = LOAD;
                        OP_MOV:                         w_next = MOV;
                        OP_ADD, OP_XOR, OP_OR, OP_AND:  w_next = ALU_A;
                        OP_BRANCH:                      w_next = BRANCH;
                        default:                        w_next = HALT;
                    endcase
                end
            end
            LOAD: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    rf_we  = 1'b1;
                    w_next = C_RET;
                end
            end
            MOV: begin
                busy   = 1'b1;
                rf_we  = 1'b1;
                w_next = C_RET;
            end
            ALU_A: begin
                busy       = 1'b1;
                acc_ld     = 1'b1;
                w_cnt_load = 1'b1;
                w_next     = ALU_EXEC;
            end
            ALU_EXEC: begin
                busy   = 1'b1;
                alu_go = 1'b1;
                if (w_cnt_zero) w_next = ALU_WB;
                else            w_cnt_dec = 1'b1;
            end
            ALU_WB: begin
                busy   = 1'b1;
                rf_we  = 1'b1;
                w_next = C_RET;
            end
            BRANCH: begin
                busy    = 1'b1;
                pc_load = cond;
                w_next  = C_RET;
            end
            HALT: begin
                halted = 1'b1;
                if (start) w_next = C_RET;
            end
            TRAP: begin
                trap = 1'b1;
            end
`ifdef CTRL_SINGLE_STEP_EN
            STEP_WAIT: begin
                busy = 1'b1;
                if (step) w_next = FETCH;
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase

        // Reset silences everything immediately, including the Mealy strobes.
        if (rst) begin
            mem_rd  = 1'b0;
            ir_load = 1'b0;
            pc_inc  = 1'b0;
            pc_load = 1'b0;
            rf_we   = 1'b0;
            acc_ld  = 1'b0;
            alu_go  = 1'b0;
            busy    = 1'b0;
            halted  = 1'b0;
            trap    = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// ============================================================================
// Module   : tb_ctrl_seq
// Purpose  : Self-checking bench for ctrl_seq; instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_seq;
    import ctrl_pkg::*;

    localparam int OPC_W   = 4;
    localparam int ALU_LAT = 3;

    // Output vector order: {mem_rd, ir_load, pc_inc, pc_load, rf_we, acc_ld, alu_go, busy, halted, trap}
    localparam logic [9:0] M_RD   = 10'b10_0000_0000;
    localparam logic [9:0] M_IR   = 10'b01_0000_0000;
    localparam logic [9:0] M_PCI  = 10'b00_1000_0000;
    localparam logic [9:0] M_PCL  = 10'b00_0100_0000;
    localparam logic [9:0] M_WE   = 10'b00_0010_0000;
    localparam logic [9:0] M_ACC  = 10'b00_0001_0000;
    localparam logic [9:0] M_ALU  = 10'b00_0000_1000;
    localparam logic [9:0] M_BUSY = 10'b00_0000_0100;
    localparam logic [9:0] M_HALT = 10'b00_0000_0010;
    localparam logic [9:0] M_TRAP = 10'b00_0000_0001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [OPC_W-1:0] opcode = '0;
    logic             mem_ready = 1'b0;
    logic             cond = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    logic             step = 1'b0;
`endif
    logic [3:0]       state;
    logic             mem_rd, ir_load, pc_inc, pc_load, rf_we;
    logic             acc_ld, alu_go, busy, halted, trap;
    logic [9:0]       obs;

    int n_vec = 0;
    int n_err = 0;

    assign obs = {mem_rd, ir_load, pc_inc, pc_load, rf_we, acc_ld, alu_go, busy, halted, trap};

    always #5 clk = ~clk;

    ctrl_seq #(
        .OPC_W   (OPC_W),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .cond      (cond),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (step),
`endif
        .state     (state),
        .mem_rd    (mem_rd),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .rf_we     (rf_we),
        .acc_ld    (acc_ld),
        .alu_go    (alu_go),
        .busy      (busy),
        .halted    (halted),
        .trap      (trap)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs (negative value = random), settle, check outputs and state.
    task automatic cyc(input string tag, input logic r, input state_t es, input logic [9:0] eo,
                       input int mr, input int st, input int cnd, input int opc, input int stp);
        @(negedge clk);
        rst       = r;
        mem_ready = (mr  < 0) ? 1'($urandom) : 1'(mr);
        start     = (st  < 0) ? 1'($urandom) : 1'(st);
        cond      = (cnd < 0) ? 1'($urandom) : 1'(cnd);
        opcode    = (opc < 0) ? OPC_W'($urandom) : OPC_W'(opc);
`ifdef CTRL_SINGLE_STEP_EN
        step      = (stp < 0) ? 1'($urandom) : 1'(stp);
`else
        if (stp > 1) $display("note: unexpected step request %0d", stp);
`endif
        #2;
        check_val({tag, ".out"}, 32'(obs), 32'(eo));
        check_val({tag, ".state"}, 32'(state), 32'(es));
    endtask

    // Return path of a completed instruction back to the fetch entry point.
    task automatic back_to_fetch();
`ifdef CTRL_SINGLE_STEP_EN
        int k;
        k = int'($urandom_range(0, 2));
        for (int i = 0; i < k; i++) cyc("step_wait", 1'b0, STEP_WAIT, M_BUSY, -1, -1, -1, -1, 0);
        cyc("step_go", 1'b0, STEP_WAIT, M_BUSY, -1, -1, -1, -1, 1);
`endif
    endtask

    task automatic idle_restart();
        cyc("idle", 1'b0, IDLE, 10'd0, -1, 0, -1, -1, -1);
        cyc("idle_go", 1'b0, IDLE, 10'd0, -1, 1, -1, -1, -1);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, starting at FETCH entry.
    task automatic run_instr(input int opc, input int fw, input int lw, input int cnd, input int hw);
        for (int i = 0; i < fw; i++) cyc("fetch_wait", 1'b0, FETCH, M_RD | M_BUSY, 0, -1, -1, -1, -1);
        cyc("fetch", 1'b0, FETCH, M_RD | M_IR | M_PCI | M_BUSY, 1, -1, -1, -1, -1);
        cyc("decode", 1'b0, DECODE, M_BUSY, -1, -1, -1, opc, -1);
        if (opc > 7) begin
            for (int i = 0; i < 3; i++) cyc("trap", 1'b0, TRAP, M_TRAP, -1, 1, -1, -1, -1);
            cyc("trap_rst", 1'b1, TRAP, 10'd0, -1, -1, -1, -1, -1);
            idle_restart();
        end else begin
            case (opc)
                0: begin
                    for (int i = 0; i < lw; i++) cyc("load_wait", 1'b0, LOAD, M_RD | M_BUSY, 0, -1, -1, -1, -1);
                    cyc("load", 1'b0, LOAD, M_RD | M_WE | M_BUSY, 1, -1, -1, -1, -1);
                end
                1: cyc("mov", 1'b0, MOV, M_WE | M_BUSY, -1, -1, -1, -1, -1);
                6: cyc("branch", 1'b0, BRANCH, (cnd != 0) ? (M_PCL | M_BUSY) : M_BUSY, -1, -1, cnd, -1, -1);
                7: begin
                    for (int i = 0; i < hw; i++) cyc("halt", 1'b0, HALT, M_HALT, -1, 0, -1, -1, -1);
                    cyc("halt_go", 1'b0, HALT, M_HALT, -1, 1, -1, -1, -1);
                end
                default: begin
                    cyc("alu_a", 1'b0, ALU_A, M_ACC | M_BUSY, -1, -1, -1, -1, -1);
                    for (int i = 0; i < ALU_LAT; i++) cyc("alu_exec", 1'b0, ALU_EXEC, M_ALU | M_BUSY, -1, -1, -1, -1, -1);
                    cyc("alu_wb", 1'b0, ALU_WB, M_WE | M_BUSY, -1, -1, -1, -1, -1);
                end
            endcase
            back_to_fetch();
        end
    endtask

    initial begin
        cyc("reset0", 1'b1, IDLE, 10'd0, 1, 1, -1, -1, -1);
        cyc("reset1", 1'b1, IDLE, 10'd0, 1, 1, -1, -1, -1);
        idle_restart();

        run_instr(2, 0, 0, 0, 0);
        run_instr(0, 1, 4, 0, 0);
        run_instr(6, 0, 0, 1, 0);
        run_instr(6, 2, 0, 0, 0);
        run_instr(1, 0, 0, 0, 0);
        run_instr(7, 0, 0, 0, 2);
        run_instr(9, 0, 0, 0, 0);

        // Reset in the middle of the ALU execute phase: no write-back may follow.
        cyc("fetch", 1'b0, FETCH, M_RD | M_IR | M_PCI | M_BUSY, 1, -1, -1, -1, -1);
        cyc("decode", 1'b0, DECODE, M_BUSY, -1, -1, -1, 3, -1);
        cyc("alu_a", 1'b0, ALU_A, M_ACC | M_BUSY, -1, -1, -1, -1, -1);
        cyc("alu_exec", 1'b0, ALU_EXEC, M_ALU | M_BUSY, -1, -1, -1, -1, -1);
        cyc("exec_rst", 1'b1, ALU_EXEC, 10'd0, -1, -1, -1, -1, -1);
        idle_restart();

        for (int n = 0; n < 80; n++) begin
            int opc;
            if ($urandom_range(0, 7) == 0) opc = int'($urandom_range(8, 15));
            else                           opc = int'($urandom_range(0, 7));
            run_instr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
